// File: rtl/pin_id_blinker.sv
// Pin-identification blinker: every led output repeats a pulse-coded copy of
// its own index (pin_base + i). One shared frame sequencer; per-pin compare.
module pin_id_blinker #(
  parameter int NUM_PINS        = 16,
  parameter int FIELD_W         = 4,
  parameter int NUM_FIELDS      = 2,
  parameter int SLOT_LOG2       = 4,
  parameter int PREAMBLE_SLOTS  = 2,
  parameter int GAP_SLOTS       = 3,
  parameter int FRAME_GAP_SLOTS = 4,
  parameter int ACTIVE_LOW      = 0,
  localparam int CW             = NUM_FIELDS * FIELD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CW-1:0]       pin_base,
  output logic [NUM_PINS-1:0] led,
  output logic                frame_start,
  output logic                busy
);

  localparam int   SW   = (FIELD_W >= 8) ? FIELD_W + 1 : 8;
  localparam int   FI_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic POL  = (ACTIVE_LOW != 0);

  localparam logic [SW-1:0]   P_LAST  = SW'(PREAMBLE_SLOTS - 1);
  localparam logic [SW-1:0]   F_LAST  = SW'((1 << FIELD_W) - 1);
  localparam logic [SW-1:0]   G_LAST  = SW'(GAP_SLOTS - 1);
  localparam logic [SW-1:0]   FG_LAST = SW'(FRAME_GAP_SLOTS - 1);
  localparam logic [FI_W-1:0] K_LAST  = FI_W'(NUM_FIELDS - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, FIELD, GAP, FRAME_GAP} state_t;

  state_t               state, n_state;
  logic [SLOT_LOG2-1:0] tick, n_tick;
  logic [SW-1:0]        slot, n_slot;
  logic [FI_W-1:0]      field, n_field;
  logic                 n_fs;
  logic [CW-1:0]        base_q;
  logic [NUM_PINS-1:0]  lit;
  logic                 slot_end;

  assign slot_end = (tick == '1);

  // Counters hold the offset currently on the outputs; led is computed from
  // the next offset so that it lines up with the registered frame_start.
  always_comb begin
    n_state = state;
    n_tick  = tick + SLOT_LOG2'(1);
    n_slot  = slot;
    n_field = field;
    n_fs    = 1'b0;
    case (state)
      IDLE: begin
        n_tick = '0;
        if (en) begin
          n_state = PREAMBLE;
          n_slot  = '0;
          n_field = '0;
          n_fs    = 1'b1;
        end
      end
      PREAMBLE: if (slot_end) begin
        if (slot == P_LAST) begin
          n_state = FIELD;
          n_slot  = '0;
          n_field = '0;
        end else n_slot = slot + SW'(1);
      end
      FIELD: if (slot_end) begin
        if (slot == F_LAST) begin
          n_slot  = '0;
          n_state = (field == K_LAST) ? FRAME_GAP : GAP;
        end else n_slot = slot + SW'(1);
      end
      GAP: if (slot_end) begin
        if (slot == G_LAST) begin
          n_state = FIELD;
          n_slot  = '0;
          n_field = field + FI_W'(1);
        end else n_slot = slot + SW'(1);
      end
      FRAME_GAP: if (slot_end) begin
        if (slot == FG_LAST) begin
          n_state = PREAMBLE;
          n_slot  = '0;
          n_field = '0;
          n_fs    = 1'b1;
        end else n_slot = slot + SW'(1);
      end
      default: n_state = IDLE;
    endcase
    if (!en) begin
      n_state = IDLE;
      n_tick  = '0;
      n_slot  = '0;
      n_field = '0;
      n_fs    = 1'b0;
    end
  end

  // Field 0 is the most significant digit of the code.
  function automatic logic [FIELD_W-1:0] field_of(input logic [CW-1:0] code,
                                                  input logic [FI_W-1:0] k);
    logic [CW-1:0] sh;
    sh = code >> ((NUM_FIELDS - 1 - int'(k)) * FIELD_W);
    return sh[FIELD_W-1:0];
  endfunction

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    logic [CW-1:0]      code;
    logic [FIELD_W-1:0] v;
    assign code   = base_q + CW'(i);
    assign v      = field_of(code, n_field);
    assign lit[i] = (n_state == PREAMBLE) ? n_tick[0]
                  : (n_state == FIELD) && n_tick[SLOT_LOG2-1] && (n_slot <= SW'(v));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick        <= '0;
      slot        <= '0;
      field       <= '0;
      base_q      <= '0;
      led         <= {NUM_PINS{POL}};
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= n_state;
      tick        <= n_tick;
      slot        <= n_slot;
      field       <= n_field;
      if (n_fs) base_q <= pin_base;
      led         <= lit ^ {NUM_PINS{POL}};
      frame_start <= n_fs;
      busy        <= (n_state != IDLE);
    end
  end

endmodule
